pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_seq_pkg.sv | 30 +++
 rtl/bit_synchronizer.sv | 33 +++
 rtl/pll_reset_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The state encoding is visible on the o_state debug port, so keep it stable.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET   = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_RUN         = 3'd4,
        ST_FAULT       = 3'd5
    } seq_state_e;

    localparam int unsigned LOSS_CNT_W = 8;

    function automatic int unsigned max_of4(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser that brings a single asynchronous level into i_clk.
// It is cleared by i_reset, so the output reads 0 until the input has propagated.
module bit_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_flop
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (i_reset) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= i_d;
                end
            end else begin : g_chain
                always_ff @(posedge i_clk) begin
                    if (i_reset) sync_q[gi] <= 1'b0;
                    else         sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock, then releases ordered stage resets.
// It retries on lock timeout, faults after repeated failures, and re-sequences on lock loss.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned QUANTITY_OF_STAGES  = 2,
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 256,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_pll_locked,
    input  logic                                i_restart,
    output logic                                o_pll_reset,
    output logic [QUANTITY_OF_STAGES-1:0]       o_stage_reset_n,
    output logic                                o_ready,
    output logic                                o_fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]    o_retry_count,
    output logic [LOSS_CNT_W-1:0]               o_lock_loss_count,
    output logic [2:0]                          o_state
);

    localparam int unsigned RETRY_W  = $clog2(MAX_RETRIES + 1);
    localparam int unsigned LAST_GAP = (QUANTITY_OF_STAGES - 1) * STAGE_GAP_CYCLES;
    localparam int unsigned CNT_MAX  = max_of4(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                               LOCK_STABLE_CYCLES, LAST_GAP);
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [QUANTITY_OF_STAGES-1:0] FIRST_STAGE  = QUANTITY_OF_STAGES'(1);
    localparam logic [QUANTITY_OF_STAGES-1:0] ALL_RELEASED = '1;

    logic                          lock_s;
    seq_state_e                    state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [CNT_W-1:0]              tmo_q;
    logic [RETRY_W-1:0]            retry_q;
    logic [LOSS_CNT_W-1:0]         loss_q;
    logic                          pll_reset_q;
    logic [QUANTITY_OF_STAGES-1:0] stages_q;
    logic                          ready_q;
    logic                          fault_q;

    logic [CNT_W-1:0]              cnt_inc;
    logic [RETRY_W-1:0]            retry_inc;
    logic [QUANTITY_OF_STAGES-1:0] stage_due;

    bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_pll_locked),
        .o_q     (lock_s)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign retry_inc = retry_q + RETRY_W'(1);

    // A stage is due once the post-bit-0 cycle count reaches its slot in the gap schedule.
    genvar gi;
    generate
        for (gi = 0; gi < QUANTITY_OF_STAGES; gi++) begin : g_due
            assign stage_due[gi] = (cnt_inc >= CNT_W'(gi * STAGE_GAP_CYCLES));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_PLL_RESET;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            stages_q    <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else if (i_restart) begin
            // The entry edge counts as the first PLL reset cycle.
            state_q     <= ST_PLL_RESET;
            cnt_q       <= CNT_W'(1);
            tmo_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            stages_q    <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RESET: begin
                    if (cnt_q == CNT_W'(PLL_RESET_CYCLES)) begin
                        state_q     <= ST_WAIT_LOCK;
                        cnt_q       <= '0;
                        tmo_q       <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= ST_LOCK_STABLE;
                        cnt_q   <= '0;
                    end else if (tmo_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_q     <= retry_inc;
                        tmo_q       <= '0;
                        pll_reset_q <= 1'b1;
                        if (retry_inc == RETRY_W'(MAX_RETRIES)) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_PLL_RESET;
                            cnt_q   <= CNT_W'(1);
                        end
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                ST_LOCK_STABLE: begin
                    // The timeout counter is left untouched so a bouncing lock still times out.
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (QUANTITY_OF_STAGES == 1) begin
                            state_q  <= ST_RUN;
                            stages_q <= ALL_RELEASED;
                            ready_q  <= 1'b1;
                            retry_q  <= '0;
                        end else begin
                            state_q  <= ST_RELEASE;
                            stages_q <= FIRST_STAGE;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!lock_s) begin
                        state_q     <= ST_PLL_RESET;
                        cnt_q       <= CNT_W'(1);
                        tmo_q       <= '0;
                        pll_reset_q <= 1'b1;
                        stages_q    <= '0;
                        ready_q     <= 1'b0;
                        if (loss_q != '1) loss_q <= loss_q + LOSS_CNT_W'(1);
                    end else if (state_q == ST_RELEASE) begin
                        cnt_q    <= cnt_inc;
                        stages_q <= stages_q | stage_due;
                        if (cnt_inc == CNT_W'(LAST_GAP)) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                            retry_q <= '0;
                        end
                    end
                end
                ST_FAULT: begin
                    pll_reset_q <= 1'b1;
                    stages_q    <= '0;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b1;
                end
                default: begin
                    state_q     <= ST_PLL_RESET;
                    cnt_q       <= '0;
                    pll_reset_q <= 1'b1;
                    stages_q    <= '0;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_reset       = pll_reset_q;
    assign o_stage_reset_n   = stages_q;
    assign o_ready           = ready_q;
    assign o_fault           = fault_q;
    assign o_retry_count     = retry_q;
    assign o_lock_loss_count = loss_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer: each edge's outputs are compared to a
// timeline computed from the sequencing rules (PLL pulse, lock qualification, stage gaps).
module tb_pll_reset_sequencer;

    localparam int Q  = 3;
    localparam int P  = 4;
    localparam int T  = 100;
    localparam int S  = 8;
    localparam int G  = 5;
    localparam int MR = 2;
    localparam int SY = 2;

    logic       clk = 1'b0;
    logic       i_reset, i_pll_locked, i_restart;
    logic       o_pll_reset, o_ready, o_fault;
    logic [2:0] o_stage_reset_n, o_state;
    logic [1:0] o_retry_count;
    logic [7:0] o_lock_loss_count;

    int vectors     = 0;
    int miscompares = 0;
    int e           = 0;
    int exp_loss    = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .QUANTITY_OF_STAGES  (Q),
        .PLL_RESET_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .STAGE_GAP_CYCLES    (G),
        .MAX_RETRIES         (MR),
        .SYNC_STAGES         (SY)
    ) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_pll_locked      (i_pll_locked),
        .i_restart         (i_restart),
        .o_pll_reset       (o_pll_reset),
        .o_stage_reset_n   (o_stage_reset_n),
        .o_ready           (o_ready),
        .o_fault           (o_fault),
        .o_retry_count     (o_retry_count),
        .o_lock_loss_count (o_lock_loss_count),
        .o_state           (o_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output vector layout: {pll_reset, stages[2:0], ready, fault, state[2:0], retry[1:0]}
    function automatic logic [10:0] got_vec();
        return {o_pll_reset, o_stage_reset_n, o_ready, o_fault, o_state, o_retry_count};
    endfunction

    // First edge spent in lock qualification, given the lock rise edge and WAIT_LOCK entry.
    function automatic int ls_edge(int t, int w);
        return (t + SY > w + 1) ? t + SY : w + 1;
    endfunction

    // Expected outputs of a sequence: PLL reset until w, waiting until ls, qualifying until rel,
    // then stage k released at rel + k*G and RUN once the last stage is out.
    function automatic logic [10:0] exp_seq(int ee, int w, int ls, int rel);
        logic       pll, rdy;
        logic [2:0] stg, st;
        pll = (ee < w);
        for (int k = 0; k < Q; k++) stg[k] = (ee >= rel + k * G);
        rdy = (ee >= rel + (Q - 1) * G);
        if (ee < w)                    st = 3'd0;
        else if (ee < ls)              st = 3'd1;
        else if (ee < rel)             st = 3'd2;
        else if (ee < rel + (Q-1) * G) st = 3'd3;
        else                           st = 3'd4;
        return {pll, stg, rdy, 1'b0, st, 2'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        i_reset      = 1'b1;
        i_restart    = 1'b0;
        i_pll_locked = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
        e        = -1;
        exp_loss = 0;
    endtask

    task automatic test_reset();
        logic [10:0] want;
        i_reset      = 1'b1;
        i_restart    = 1'b0;
        i_pll_locked = 1'b1;
        want = {1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 2'd0};
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'd0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %b loss %0d, want %b loss 0", i, got_vec(), o_lock_loss_count, want);
            end
        end
        $display("reset: %0d cycles checked", 3);
    endtask

    task automatic test_nominal(input int t);
        int ls, rel, stop, bad;
        logic [10:0] want;
        do_reset();
        ls   = ls_edge(t, P);
        rel  = ls + S;
        stop = rel + (Q - 1) * G + 3;
        bad  = 0;
        while (e < stop) begin
            if (e + 1 >= t) i_pll_locked = 1'b1;
            tick();
            want = exp_seq(e, P, ls, rel);
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'd0) begin
                miscompares++; bad++;
                $display("FAIL nominal(t=%0d) edge %0d: got %b loss %0d, want %b loss 0", t, e, got_vec(), o_lock_loss_count, want);
            end
        end
        $display("nominal: lock at %0d, bit0 expected at %0d, %0d bad edges", t, rel, bad);
    endtask

    task automatic test_glitch();
        int ls1, drop, ls2, rel, bad;
        logic [10:0] want;
        do_reset();
        ls1  = 10 + SY;
        drop = 15 + SY;
        ls2  = 20 + SY;
        rel  = ls2 + S;
        bad  = 0;
        while (e < rel + (Q - 1) * G + 3) begin
            i_pll_locked = ((e + 1 >= 10) && (e + 1 <= 14)) || (e + 1 >= 20);
            tick();
            want = exp_seq(e, P, ls2, rel);
            if (e >= ls1 && e < ls2) want[4:2] = (e < drop) ? 3'd2 : 3'd1;
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'd0) begin
                miscompares++; bad++;
                $display("FAIL glitch edge %0d: got %b loss %0d, want %b loss 0", e, got_vec(), o_lock_loss_count, want);
            end
        end
        $display("glitch: bit0 expected at %0d, %0d bad edges", rel, bad);
    endtask

    task automatic test_timeout_fault();
        int tmo1, w2, flt, bad;
        logic [2:0]  st;
        logic [1:0]  rt;
        logic [10:0] want;
        do_reset();
        tmo1 = P + T;
        w2   = tmo1 + P;
        flt  = w2 + T;
        bad  = 0;
        while (e < flt + 8) begin
            tick();
            if (e < P)         st = 3'd0;
            else if (e < tmo1) st = 3'd1;
            else if (e < w2)   st = 3'd0;
            else if (e < flt)  st = 3'd1;
            else               st = 3'd5;
            rt   = (e < tmo1) ? 2'd0 : (e < flt) ? 2'd1 : 2'd2;
            want = {(st == 3'd0 || st == 3'd5), 3'b000, 1'b0, (e >= flt), st, rt};
            vectors++;
            if (got_vec() !== want) begin
                miscompares++; bad++;
                $display("FAIL timeout edge %0d: got %b, want %b", e, got_vec(), want);
            end
        end
        $display("timeout: fault expected at %0d, %0d bad edges", flt, bad);
    endtask

    task automatic test_restart_from_fault();
        int r, ls, rel, bad;
        logic [10:0] want;
        r   = e + 1;
        ls  = ls_edge(r, r + P);
        rel = ls + S;
        bad = 0;
        while (e < rel + (Q - 1) * G + 3) begin
            i_restart    = (e + 1 == r);
            i_pll_locked = 1'b1;
            tick();
            want = exp_seq(e, r + P, ls, rel);
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'(exp_loss)) begin
                miscompares++; bad++;
                $display("FAIL restart_fault edge %0d: got %b loss %0d, want %b loss %0d", e, got_vec(), o_lock_loss_count, want, exp_loss);
            end
        end
        i_restart = 1'b0;
        $display("restart_fault: restart at %0d, %0d bad edges", r, bad);
    endtask

    task automatic test_runtime_loss();
        int d, w, l, ls, rel, base, bad;
        logic [10:0] want;
        d    = e + 1 + $urandom_range(0, 8);
        w    = $urandom_range(1, 3);
        l    = d + SY;
        ls   = ls_edge(d + w, l + P);
        rel  = ls + S;
        base = exp_loss;
        bad  = 0;
        while (e < rel + (Q - 1) * G + 3) begin
            i_pll_locked = !((e + 1 >= d) && (e + 1 < d + w));
            tick();
            if (e < l) want = {1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 2'd0};
            else       want = exp_seq(e, l + P, ls, rel);
            exp_loss = (e >= l) ? base + 1 : base;
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'(exp_loss)) begin
                miscompares++; bad++;
                $display("FAIL runtime_loss edge %0d: got %b loss %0d, want %b loss %0d", e, got_vec(), o_lock_loss_count, want, exp_loss);
            end
        end
        $display("runtime_loss: drop %0d for %0d, loss count %0d, %0d bad edges", d, w, exp_loss, bad);
    endtask

    task automatic test_restart_priority();
        int d, r0, h, r, ls, rel, bad;
        logic [10:0] want;
        // Restart lands on the same edge the lock loss is first seen; the loss is not counted.
        d   = e + 1 + $urandom_range(0, 5);
        r   = d + SY;
        ls  = ls_edge(d + 1, r + P);
        rel = ls + S;
        bad = 0;
        while (e < rel + (Q - 1) * G + 3) begin
            i_pll_locked = (e + 1 != d);
            i_restart    = (e + 1 == r);
            tick();
            if (e < r) want = {1'b0, 3'b111, 1'b1, 1'b0, 3'd4, 2'd0};
            else       want = exp_seq(e, r + P, ls, rel);
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'(exp_loss)) begin
                miscompares++; bad++;
                $display("FAIL restart_loss edge %0d: got %b loss %0d, want %b loss %0d", e, got_vec(), o_lock_loss_count, want, exp_loss);
            end
        end
        // A held restart keeps the block in PLL_RESET until it drops.
        r0  = e + 1;
        h   = $urandom_range(2, 6);
        r   = r0 + h - 1;
        ls  = ls_edge(r0, r + P);
        rel = ls + S;
        while (e < rel + (Q - 1) * G + 3) begin
            i_restart = (e + 1 >= r0) && (e + 1 <= r);
            tick();
            want = exp_seq(e, r + P, ls, rel);
            vectors++;
            if (got_vec() !== want || o_lock_loss_count !== 8'(exp_loss)) begin
                miscompares++; bad++;
                $display("FAIL restart_held edge %0d: got %b loss %0d, want %b loss %0d", e, got_vec(), o_lock_loss_count, want, exp_loss);
            end
        end
        i_restart = 1'b0;
        $display("restart_priority: held %0d cycles, %0d bad edges", h, bad);
    endtask

    task automatic test_reset_mid_release();
        int r, ls, rel, x, bad;
        logic [10:0] want;
        r   = e + 1;
        ls  = ls_edge(r, r + P);
        rel = ls + S;
        x   = rel + G + 2;
        bad = 0;
        while (e < x - 1) begin
            i_restart = (e + 1 == r);
            tick();
            want = exp_seq(e, r + P, ls, rel);
            vectors++;
            if (got_vec() !== want) begin
                miscompares++; bad++;
                $display("FAIL mid_release edge %0d: got %b, want %b", e, got_vec(), want);
            end
        end
        i_restart = 1'b0;
        i_reset   = 1'b1;
        tick();
        want = {1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 2'd0};
        vectors++;
        if (got_vec() !== want || o_lock_loss_count !== 8'd0) begin
            miscompares++; bad++;
            $display("FAIL mid_release_reset edge %0d: got %b loss %0d, want %b loss 0", e, got_vec(), o_lock_loss_count, want);
        end
        i_reset = 1'b0;
        $display("reset_mid_release: reset at %0d, %0d bad edges", x, bad);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_restart    = 1'b0;
        i_pll_locked = 1'b0;
        test_reset();
        test_nominal(10);
        for (int i = 0; i < 3; i++) test_nominal(int'($urandom_range(1, 60)));
        test_glitch();
        test_timeout_fault();
        test_restart_from_fault();
        test_runtime_loss();
        test_runtime_loss();
        test_restart_priority();
        test_reset_mid_release();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
